// File: rtl/down_counter_timer.sv
// Loadable down-counter/timer with underflow pulse,
// periodic auto-reload or one-shot halt in DONE.
module down_counter_timer #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             en,
  input  logic             auto_reload,
  output logic [WIDTH-1:0] count,
  output logic             underflow,
  output logic             busy,
  output logic             done
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] count_q, count_d;
  logic [WIDTH-1:0] reload_q, reload_d;
  logic             uf_q, uf_d;
  logic             busy_q, done_q;

  // Next-state: load wins, else per-state count/reload/halt
  always_comb begin
    state_d  = state_q;
    count_d  = count_q;
    reload_d = reload_q;
    uf_d     = 1'b0;
    if (load) begin
      count_d  = load_val;
      reload_d = load_val;
      state_d  = (load_val != '0) ? RUN : DONE;
    end else begin
      unique case (state_q)
        IDLE: count_d = '0;
        RUN: begin
          if (en) begin
            if (count_q > WIDTH'(1)) begin
              count_d = count_q - WIDTH'(1);
            end else if (count_q == WIDTH'(1)) begin
              count_d = '0;
              uf_d    = 1'b1;
            end else if (auto_reload) begin
              count_d = reload_q;
            end else begin
              state_d = DONE;
            end
          end
        end
        DONE: count_d = '0;
        default: begin
          state_d = IDLE;
          count_d = '0;
        end
      endcase
    end
  end

  // State and registered outputs, synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      count_q  <= '0;
      reload_q <= '0;
      uf_q     <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      count_q  <= count_d;
      reload_q <= reload_d;
      uf_q     <= uf_d;
      busy_q   <= (state_d == RUN);
      done_q   <= (state_d == DONE);
    end
  end

  assign count     = count_q;
  assign underflow = uf_q;
  assign busy      = busy_q;
  assign done      = done_q;

endmodule

// File: tb/tb_down_counter_timer.sv
// Directed bench for down_counter_timer,
// hand-computed expectations checked with assertions.
module tb_down_counter_timer;

  logic       clk;
  logic       rst;
  logic       load;
  logic [7:0] load_val;
  logic       en;
  logic       auto_reload;
  logic [7:0] count;
  logic       underflow;
  logic       busy;
  logic       done;

  int errs;
  int checks;

  down_counter_timer #(.WIDTH(8)) dut (
    .clk        (clk),
    .rst        (rst),
    .load       (load),
    .load_val   (load_val),
    .en         (en),
    .auto_reload(auto_reload),
    .count      (count),
    .underflow  (underflow),
    .busy       (busy),
    .done       (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_all(input string tag,
                         input logic [7:0] c,
                         input logic u,
                         input logic b,
                         input logic d);
    chk({tag, ".count"}, {24'd0, count}, {24'd0, c});
    chk({tag, ".uf"}, {31'd0, underflow}, {31'd0, u});
    chk({tag, ".busy"}, {31'd0, busy}, {31'd0, b});
    chk({tag, ".done"}, {31'd0, done}, {31'd0, d});
  endtask

  initial begin
    errs = 0;
    checks = 0;
    rst = 1'b1;
    load = 1'b0;
    load_val = 8'h00;
    en = 1'b0;
    auto_reload = 1'b0;

    // 1: reset
    tick(2);
    chk_all("reset", 8'h00, 1'b0, 1'b0, 1'b0);

    // IDLE ignores en
    rst = 1'b0;
    en = 1'b1;
    tick(3);
    chk_all("idle_en", 8'h00, 1'b0, 1'b0, 1'b0);

    // 2: load FF, auto-reload
    load = 1'b1;
    load_val = 8'hFF;
    auto_reload = 1'b1;
    tick(1);
    load = 1'b0;
    chk_all("ldFF", 8'hFF, 1'b0, 1'b1, 1'b0);
    tick(254);
    chk_all("ldFF_254", 8'h01, 1'b0, 1'b1, 1'b0);
    tick(1);
    chk_all("ldFF_255", 8'h00, 1'b1, 1'b1, 1'b0);
    tick(1);
    chk_all("ldFF_rel", 8'hFF, 1'b0, 1'b1, 1'b0);

    // auto-reload period = load_val+1
    load = 1'b1;
    load_val = 8'h02;
    tick(1);
    load = 1'b0;
    chk_all("p_ld", 8'h02, 1'b0, 1'b1, 1'b0);
    tick(2);
    chk_all("p_uf1", 8'h00, 1'b1, 1'b1, 1'b0);
    en = 1'b0;
    tick(1);
    chk_all("p_hold0", 8'h00, 1'b0, 1'b1, 1'b0);
    en = 1'b1;
    tick(1);
    chk_all("p_rel", 8'h02, 1'b0, 1'b1, 1'b0);
    tick(2);
    chk_all("p_uf2", 8'h00, 1'b1, 1'b1, 1'b0);

    // 3: one-shot 0A
    load = 1'b1;
    load_val = 8'h0A;
    auto_reload = 1'b0;
    tick(1);
    load = 1'b0;
    chk_all("os_ld", 8'h0A, 1'b0, 1'b1, 1'b0);
    tick(10);
    chk_all("os_uf", 8'h00, 1'b1, 1'b1, 1'b0);
    tick(1);
    chk_all("os_done", 8'h00, 1'b0, 1'b0, 1'b1);
    auto_reload = 1'b1;
    tick(5);
    chk_all("os_hold", 8'h00, 1'b0, 1'b0, 1'b1);

    // 4: en gating
    load = 1'b1;
    load_val = 8'h05;
    en = 1'b0;
    tick(1);
    load = 1'b0;
    tick(3);
    chk_all("en0", 8'h05, 1'b0, 1'b1, 1'b0);
    en = 1'b1;
    tick(2);
    chk_all("en1", 8'h03, 1'b0, 1'b1, 1'b0);

    // 5: reload mid-count, then rst
    load = 1'b1;
    load_val = 8'h20;
    tick(1);
    load = 1'b0;
    chk_all("reld", 8'h20, 1'b0, 1'b1, 1'b0);
    tick(1);
    chk_all("reld_dec", 8'h1F, 1'b0, 1'b1, 1'b0);
    rst = 1'b1;
    load = 1'b1;
    load_val = 8'h44;
    tick(1);
    rst = 1'b0;
    load = 1'b0;
    chk_all("rst_run", 8'h00, 1'b0, 1'b0, 1'b0);

    // 6: load zero -> DONE, no underflow
    load = 1'b1;
    load_val = 8'h00;
    tick(1);
    load = 1'b0;
    chk_all("ld0", 8'h00, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 3; i++) begin
      tick(1);
      chk("ld0_nouf", {31'd0, underflow}, 32'd0);
    end

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
